// File: rtl/run_monitor_pkg.sv
// Shared types for run_monitor: FSM state and fail-code encodings with their widths.
package run_monitor_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned FAIL_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [FAIL_W-1:0] {
    FAIL_NONE    = 2'd0,
    FAIL_ERR     = 2'd1,
    FAIL_TIMEOUT = 2'd2
  } fail_e;

endpackage

// File: rtl/run_monitor_chan.sv
// Per-channel WIDTH-bit saturating event counter with synchronous clear.
// cnt_nxt exposes the value being loaded so the parent can decide exits on it.
module run_monitor_chan #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             clr,
  input  logic             en,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] cnt_nxt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;

endmodule

// File: rtl/run_monitor.sv
// Run monitor: arms on start, counts RUN cycles and per-channel events, and
// latches a pass/error/timeout verdict. Optional macro RUN_MONITOR_FINISH_EN ends simulation on DONE.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned NCH            = 4,
  parameter int unsigned EV_TARGET      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 start,
  input  logic [NCH-1:0]       ev_valid,
  input  logic [NCH-1:0]       ev_err,
  output logic [STATE_W-1:0]   state,
  output logic [WIDTH-1:0]     cycle_cnt,
  output logic [NCH*WIDTH-1:0] ev_cnt,
  output logic                 done,
  output logic                 done_pulse,
  output logic [FAIL_W-1:0]    fail_code
);

  // Wide enough to compare a counter against a 32-bit parameter without truncation.
  localparam int unsigned CMP_W = WIDTH + 32;

  state_e           state_q, state_d;
  fail_e            fail_q, fail_d;
  logic             done_q, done_d;
  logic             done_pulse_q, done_pulse_d;
  logic [WIDTH-1:0] cyc_q, cyc_d, cyc_nxt;
  logic [WIDTH-1:0] ev_nxt [NCH];
  logic             run;
  logic             arm;
  logic             all_met;

  assign run = (state_q == ST_RUN);
  assign arm = start && !run;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    run_monitor_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk    (clk),
      .reset_l(reset_l),
      .clr    (arm),
      .en     (run),
      .inc    (ev_valid[g]),
      .cnt    (ev_cnt[g*WIDTH +: WIDTH]),
      .cnt_nxt(ev_nxt[g])
    );
  end

  assign cyc_nxt = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;

  always_comb begin
    all_met = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (CMP_W'(ev_nxt[i]) < CMP_W'(EV_TARGET)) begin
        all_met = 1'b0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    fail_d       = fail_q;
    cyc_d        = cyc_q;
    done_pulse_d = 1'b0;
    if (run) begin
      cyc_d = cyc_nxt;
      if (|ev_err) begin
        state_d      = ST_DONE;
        fail_d       = FAIL_ERR;
        done_pulse_d = 1'b1;
      end else if (all_met) begin
        state_d      = ST_DONE;
        fail_d       = FAIL_NONE;
        done_pulse_d = 1'b1;
      end else if (CMP_W'(cyc_nxt) == CMP_W'(TIMEOUT_CYCLES)) begin
        state_d      = ST_DONE;
        fail_d       = FAIL_TIMEOUT;
        done_pulse_d = 1'b1;
      end
    end else if (start) begin
      state_d = ST_RUN;
      fail_d  = FAIL_NONE;
      cyc_d   = '0;
    end else if (state_q != ST_DONE) begin
      // Folds the unused encoding back to IDLE.
      state_d = ST_IDLE;
    end
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q      <= ST_IDLE;
      fail_q       <= FAIL_NONE;
      cyc_q        <= '0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fail_q       <= fail_d;
      cyc_q        <= cyc_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign state      = state_q;
  assign cycle_cnt  = cyc_q;
  assign done       = done_q;
  assign done_pulse = done_pulse_q;
  assign fail_code  = fail_q;

  a_no_state3: assert property (@(posedge clk) disable iff (!reset_l) state_q != 2'd3);
  c_fail_none: cover property (@(posedge clk) done_pulse_q && (fail_q == FAIL_NONE));
  c_fail_err:  cover property (@(posedge clk) done_pulse_q && (fail_q == FAIL_ERR));
  c_fail_tmo:  cover property (@(posedge clk) done_pulse_q && (fail_q == FAIL_TIMEOUT));

`ifdef RUN_MONITOR_FINISH_EN
  always_ff @(posedge clk) begin
    if (reset_l && done_pulse_q) begin
      if (fail_q == FAIL_NONE) begin
        $write("*-* All Finished *-*\n");
        $finish;
      end else begin
        $error("run_monitor finished with fail_code=%0d", fail_q);
        $finish;
      end
    end
  end
`endif

endmodule
